// File: rtl/change_payout_controller.sv
// Coin-out controller: pays an amount as Rs10/Rs5 hopper ejects and keeps the coin inventory.
// Optional ack watchdog / hopper_jam flag enabled by defining PAYOUT_TIMEOUT_EN.
module change_payout_controller #(
  parameter int AMT_W       = 8,
  parameter int CNT_W       = 6,
  parameter int INIT_FIVE   = 20,
  parameter int INIT_TEN    = 20,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             payout_req,
  input  logic [AMT_W-1:0] payout_amount,
  input  logic             coin_ack,
  input  logic             refill_five,
  input  logic             refill_ten,
  output logic             eject_five,
  output logic             eject_ten,
  output logic             busy,
  output logic             payout_done,
  output logic             payout_short,
  output logic [AMT_W-1:0] remaining,
  output logic [CNT_W-1:0] five_count,
  output logic [CNT_W-1:0] ten_count,
  output logic             hopper_jam
);

`ifdef PAYOUT_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int               WD_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(ACK_TIMEOUT - 1);
  localparam logic [AMT_W-1:0] TEN_AMT  = AMT_W'(10);
  localparam logic [AMT_W-1:0] FIVE_AMT = AMT_W'(5);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {IDLE, SELECT, WAIT_ACK, DONE, SHORT} state_t;

  state_t             state_reg, state_next;
  logic [AMT_W-1:0]   remaining_reg, remaining_next;
  logic               coin_ten_reg, coin_ten_next;
  logic               issued_reg;
  logic [WD_W-1:0]    wd_reg, wd_next;
  logic               jam_reg, jam_next;
  logic               busy_reg, done_reg, short_reg;
  logic               eject_five_reg, eject_ten_reg;
  logic               dec_five, dec_ten;
  logic [1:0]         inc_vec, dec_vec;
  logic [1:0][CNT_W-1:0] count_vec;

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    coin_ten_next  = coin_ten_reg;
    wd_next        = '0;
    jam_next       = jam_reg;
    dec_five       = 1'b0;
    dec_ten        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (payout_req) begin
          remaining_next = payout_amount;
          jam_next       = 1'b0;
          state_next     = SELECT;
        end
      end
      SELECT: begin
        if (remaining_reg == '0) begin
          state_next = DONE;
        end else if (remaining_reg >= TEN_AMT && count_vec[1] != '0) begin
          coin_ten_next = 1'b1;
          state_next    = WAIT_ACK;
        end else if (remaining_reg >= FIVE_AMT && count_vec[0] != '0) begin
          coin_ten_next = 1'b0;
          state_next    = WAIT_ACK;
        end else begin
          state_next = SHORT;
        end
      end
      WAIT_ACK: begin
        // An ack is only meaningful once the eject pulse has actually gone out.
        if (issued_reg && coin_ack) begin
          remaining_next = remaining_reg - (coin_ten_reg ? TEN_AMT : FIVE_AMT);
          dec_ten        = coin_ten_reg;
          dec_five       = !coin_ten_reg;
          state_next     = SELECT;
        end else if (issued_reg) begin
          if (TIMEOUT_EN && wd_reg == WD_LAST) begin
            jam_next   = 1'b1;
            state_next = SHORT;
          end else begin
            wd_next = wd_reg + 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      SHORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      remaining_reg  <= '0;
      coin_ten_reg   <= 1'b0;
      issued_reg     <= 1'b0;
      wd_reg         <= '0;
      jam_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      short_reg      <= 1'b0;
      eject_five_reg <= 1'b0;
      eject_ten_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      remaining_reg  <= remaining_next;
      coin_ten_reg   <= coin_ten_next;
      wd_reg         <= wd_next;
      jam_reg        <= TIMEOUT_EN ? jam_next : 1'b0;
      busy_reg       <= (state_next != IDLE);
      // Pulses are registered decodes of the state being left, one cycle behind it.
      issued_reg     <= (state_reg == WAIT_ACK) && (state_next == WAIT_ACK);
      eject_ten_reg  <= (state_reg == WAIT_ACK) && !issued_reg && coin_ten_reg;
      eject_five_reg <= (state_reg == WAIT_ACK) && !issued_reg && !coin_ten_reg;
      done_reg       <= (state_reg == DONE);
      short_reg      <= (state_reg == SHORT);
    end
  end

  assign inc_vec = {refill_ten, refill_five};
  assign dec_vec = {dec_ten, dec_five};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_inv
      localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(gi == 0 ? INIT_FIVE : INIT_TEN);
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clock) begin
        if (reset) begin
          cnt_reg <= INIT_CNT;
        end else if (inc_vec[gi] && !dec_vec[gi] && cnt_reg != CNT_MAX) begin
          cnt_reg <= cnt_reg + 1'b1;
        end else if (dec_vec[gi] && !inc_vec[gi] && cnt_reg != '0) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
      assign count_vec[gi] = cnt_reg;
    end
  endgenerate

  assign eject_five   = eject_five_reg;
  assign eject_ten    = eject_ten_reg;
  assign busy         = busy_reg;
  assign payout_done  = done_reg;
  assign payout_short = short_reg;
  assign remaining    = remaining_reg;
  assign five_count   = count_vec[0];
  assign ten_count    = count_vec[1];
  assign hopper_jam   = jam_reg;

endmodule

// File: tb/tb_change_payout_controller.sv
// Directed bench for change_payout_controller (default build, watchdog disabled).
module tb_change_payout_controller;
  logic       clock = 1'b0;
  logic       reset, payout_req, coin_ack, refill_five, refill_ten;
  logic [7:0] payout_amount;
  logic       eject_five, eject_ten, busy, payout_done, payout_short, hopper_jam;
  logic [7:0] remaining;
  logic [5:0] five_count, ten_count;

  int vectors = 0;
  int miscompares = 0;
  int n_ten, n_five;
  bit got_done, got_short;

  change_payout_controller dut (
    .clock(clock), .reset(reset), .payout_req(payout_req), .payout_amount(payout_amount),
    .coin_ack(coin_ack), .refill_five(refill_five), .refill_ten(refill_ten),
    .eject_five(eject_five), .eject_ten(eject_ten), .busy(busy),
    .payout_done(payout_done), .payout_short(payout_short), .remaining(remaining),
    .five_count(five_count), .ten_count(ten_count), .hopper_jam(hopper_jam)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One payout with an ack two cycles after each eject; bounded by a cycle budget.
  task automatic run_payout(input logic [7:0] amt);
    n_ten = 0; n_five = 0; got_done = 0; got_short = 0;
    payout_req = 1'b1; payout_amount = amt;
    tick();
    payout_req = 1'b0;
    for (int c = 0; c < 400 && !(got_done || got_short); c++) begin
      tick();
      if (eject_ten) n_ten++;
      if (eject_five) n_five++;
      if (payout_done) got_done = 1;
      if (payout_short) got_short = 1;
      if (eject_ten || eject_five) begin
        tick();
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
      end
    end
    chk("payout_finished_in_budget", 32'(got_done || got_short), 32'd1);
  endtask

  initial begin
    reset = 1'b1; payout_req = 1'b0; payout_amount = '0; coin_ack = 1'b0;
    refill_five = 1'b0; refill_ten = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_remaining", 32'(remaining), 32'd0);
    chk("rst_five", 32'(five_count), 32'd20);
    chk("rst_ten", 32'(ten_count), 32'd20);
    chk("rst_pulses", 32'({eject_five, eject_ten, payout_done, payout_short}), 32'd0);
    chk("rst_jam", 32'(hopper_jam), 32'd0);
    reset = 1'b0;

    // 15 rupees: ten first, then five, with exact latency
    payout_req = 1'b1; payout_amount = 8'd15;
    tick();
    payout_req = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_latched", 32'(remaining), 32'd15);
    tick();
    chk("t1_no_early_eject", 32'(eject_ten), 32'd0);
    tick();
    chk("t1_eject_ten", 32'(eject_ten), 32'd1);
    chk("t1_no_five_yet", 32'(eject_five), 32'd0);
    tick();
    chk("t1_ten_one_cycle", 32'(eject_ten), 32'd0);
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    chk("t1_rem_after_ten", 32'(remaining), 32'd5);
    chk("t1_ten_count", 32'(ten_count), 32'd19);
    tick();
    tick();
    chk("t1_eject_five", 32'(eject_five), 32'd1);
    tick();
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    chk("t1_rem_zero", 32'(remaining), 32'd0);
    chk("t1_five_count", 32'(five_count), 32'd19);
    tick();
    chk("t1_done_not_yet", 32'(payout_done), 32'd0);
    tick();
    chk("t1_done", 32'(payout_done), 32'd1);
    chk("t1_idle", 32'(busy), 32'd0);
    tick();
    chk("t1_done_one_cycle", 32'(payout_done), 32'd0);

    // Zero amount
    reset = 1'b1; tick(); reset = 1'b0;
    payout_req = 1'b1; payout_amount = 8'd0;
    tick();
    payout_req = 1'b0;
    chk("t2_done_n0", 32'(payout_done), 32'd0);
    tick();
    chk("t2_done_n1", 32'(payout_done), 32'd0);
    tick();
    chk("t2_done_n2", 32'(payout_done), 32'd1);
    chk("t2_no_eject", 32'({eject_five, eject_ten}), 32'd0);

    // Drain tens, then fives down to one
    run_payout(8'd200);
    chk("drain_tens_n", 32'(n_ten), 32'd20);
    chk("drain_tens_done", 32'(got_done), 32'd1);
    chk("drain_ten_count", 32'(ten_count), 32'd0);
    run_payout(8'd95);
    chk("drain_fives_n", 32'(n_five), 32'd19);
    chk("drain_five_count", 32'(five_count), 32'd1);

    // Inventory runs out
    run_payout(8'd20);
    chk("t3_one_five", 32'(n_five), 32'd1);
    chk("t3_no_ten", 32'(n_ten), 32'd0);
    chk("t3_short", 32'(got_short), 32'd1);
    chk("t3_no_done", 32'(got_done), 32'd0);
    chk("t3_residue", 32'(remaining), 32'd15);
    chk("t3_five_empty", 32'(five_count), 32'd0);

    // Amount not divisible by 5
    refill_ten = 1'b1; tick(); refill_ten = 1'b0;
    chk("t4_refill_ten", 32'(ten_count), 32'd1);
    run_payout(8'd12);
    chk("t4_one_ten", 32'(n_ten), 32'd1);
    chk("t4_short", 32'(got_short), 32'd1);
    chk("t4_residue", 32'(remaining), 32'd2);
    chk("t4_ten_empty", 32'(ten_count), 32'd0);

    // Stray ack in IDLE does nothing
    coin_ack = 1'b1; tick(); coin_ack = 1'b0;
    chk("idle_ack_rem", 32'(remaining), 32'd2);
    chk("idle_ack_busy", 32'(busy), 32'd0);

    // Saturation
    refill_five = 1'b1; repeat (70) tick(); refill_five = 1'b0;
    chk("five_saturates", 32'(five_count), 32'd63);

    // Refill on ack cycle nets out; request while busy is ignored
    refill_ten = 1'b1; repeat (2) tick(); refill_ten = 1'b0;
    chk("t5_ten_two", 32'(ten_count), 32'd2);
    payout_req = 1'b1; payout_amount = 8'd10;
    tick();
    payout_req = 1'b0;
    tick();
    tick();
    chk("t5_eject_ten", 32'(eject_ten), 32'd1);
    tick();
    coin_ack = 1'b1; refill_ten = 1'b1; payout_req = 1'b1; payout_amount = 8'd50;
    tick();
    coin_ack = 1'b0; refill_ten = 1'b0; payout_req = 1'b0;
    chk("t5_ten_net", 32'(ten_count), 32'd2);
    chk("t5_rem_zero", 32'(remaining), 32'd0);
    tick();
    tick();
    chk("t5_done", 32'(payout_done), 32'd1);
    tick();
    chk("t5_req_ignored_busy", 32'(busy), 32'd0);
    chk("t5_req_ignored_rem", 32'(remaining), 32'd0);

    // Reset while waiting for ack aborts silently
    payout_req = 1'b1; payout_amount = 8'd10;
    tick();
    payout_req = 1'b0;
    tick();
    tick();
    chk("t6_eject_ten", 32'(eject_ten), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rem", 32'(remaining), 32'd0);
    chk("t6_ten", 32'(ten_count), 32'd20);
    chk("t6_five", 32'(five_count), 32'd20);
    chk("t6_eject_clr", 32'(eject_ten), 32'd0);
    tick();
    tick();
    chk("t6_no_end_pulse", 32'({payout_done, payout_short}), 32'd0);
    chk("t6_jam", 32'(hopper_jam), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
